// File: rtl/chan_rr_scheduler_if.sv
// Request/response bundle between CHANNEL requesters, the round-robin scheduler
// and the shared downstream slot.
//
// Handshake: a word moves when valid and ready are both 1 on a rising clk edge.
// A requester keeps valid and data stable until that edge. req_ready never
// waits on valid, and out_ready may be held high without a word present.
interface chan_rr_scheduler_if #(
   parameter int WIDTH   = 32,
   parameter int CHANNEL = 5
);
   localparam int CHAN_W = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;

   logic [CHANNEL-1:0]       req_valid;
   logic [CHANNEL*WIDTH-1:0] req_data;
   logic [CHANNEL-1:0]       req_ready;
   logic                     out_valid;
   logic [WIDTH-1:0]         out_data;
   logic [CHAN_W-1:0]        out_chan;
   logic                     out_ready;

   modport master (
      output req_valid, req_data, out_ready,
      input  req_ready, out_valid, out_data, out_chan
   );

   modport slave (
      input  req_valid, req_data, out_ready,
      output req_ready, out_valid, out_data, out_chan
   );
endinterface

// File: rtl/chan_rr_scheduler.sv
// Round-robin scheduler with burst lock that shares one registered output slot
// among CHANNEL requesters; the output word carries its source channel tag.
module chan_rr_scheduler #(
   parameter int WIDTH   = 32,
   parameter int CHANNEL = 5,
   parameter int BURST   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   chan_rr_scheduler_if.slave    bus_io,
   output logic                  locked_o
);
   localparam int CHAN_W = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;

   typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_e;

   state_e              state_q, state_d;
   logic [CHAN_W-1:0]   ptr_q, ptr_d;
   logic [CHAN_W-1:0]   lock_ch_q, lock_ch_d;
   logic [7:0]          beat_cnt_q, beat_cnt_d;
   logic                out_valid_q, out_valid_d;
   logic [WIDTH-1:0]    out_data_q, out_data_d;
   logic [CHAN_W-1:0]   out_chan_q, out_chan_d;

   logic                slot_free, lock_hold, found, xfer;
   logic [CHAN_W-1:0]   start, idx, sel;
   logic [7:0]          beat_inc;
   logic [CHANNEL-1:0]  req_ready;
   logic [WIDTH-1:0]    words [CHANNEL];

   function automatic logic [CHAN_W-1:0] wrap_inc(input logic [CHAN_W-1:0] c);
      return (c == CHAN_W'(CHANNEL - 1)) ? '0 : c + 1'b1;
   endfunction

   for (genvar g = 0; g < CHANNEL; g++) begin : g_unpack
      assign words[g] = bus_io.req_data[g*WIDTH +: WIDTH];
   end

   // A lock whose channel has dropped valid releases in the same cycle and the
   // search resumes just past it, so another requester loses no beat.
   always_comb begin
      slot_free = !out_valid_q || bus_io.out_ready;
      lock_hold = (state_q == S_LOCK) && bus_io.req_valid[lock_ch_q];
      start     = (state_q == S_LOCK) ? wrap_inc(lock_ch_q) : ptr_q;
      found     = lock_hold;
      sel       = lock_ch_q;
      idx       = start;
      for (int k = 0; k < CHANNEL; k++) begin
         if (!found && bus_io.req_valid[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
         idx = wrap_inc(idx);
      end
      xfer      = slot_free && found && !rst;
      req_ready = '0;
      if (xfer) req_ready[sel] = 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      lock_ch_d   = lock_ch_q;
      beat_cnt_d  = beat_cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      beat_inc    = beat_cnt_q + 8'd1;

      if (state_q == S_LOCK && !bus_io.req_valid[lock_ch_q] && slot_free) begin
         state_d    = S_IDLE;
         beat_cnt_d = '0;
      end

      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = words[sel];
         out_chan_d  = sel;
         ptr_d       = wrap_inc(sel);
         if (lock_hold) begin
            if (beat_inc == 8'(BURST)) begin
               state_d    = S_IDLE;
               beat_cnt_d = '0;
            end else begin
               beat_cnt_d = beat_inc;
            end
         end else begin
            lock_ch_d  = sel;
            beat_cnt_d = 8'd1;
            state_d    = (BURST > 1) ? S_LOCK : S_IDLE;
         end
      end else if (bus_io.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         lock_ch_q   <= '0;
         beat_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         lock_ch_q   <= lock_ch_d;
         beat_cnt_q  <= beat_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
      end
   end

   assign bus_io.req_ready = req_ready;
   assign bus_io.out_valid = out_valid_q;
   assign bus_io.out_data  = out_data_q;
   assign bus_io.out_chan  = out_chan_q;
   assign locked_o         = (state_q == S_LOCK);
endmodule

// File: tb/tb_chan_rr_scheduler.sv
// Directed bench for chan_rr_scheduler: one instance with BURST=1 and one with
// BURST=4, expected output words queued as stimulus is applied.
module tb_chan_rr_scheduler;
   localparam int WIDTH   = 32;
   localparam int CHANNEL = 5;
   localparam int CHAN_W  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic locked1, locked4;
   int   n_assert = 0;
   int   n_fail   = 0;
   logic [CHAN_W+WIDTH-1:0] exp_q1[$];
   logic [CHAN_W+WIDTH-1:0] exp_q4[$];

   always #5 clk = ~clk;

   chan_rr_scheduler_if #(.WIDTH(WIDTH), .CHANNEL(CHANNEL)) if1 ();
   chan_rr_scheduler_if #(.WIDTH(WIDTH), .CHANNEL(CHANNEL)) if4 ();

   chan_rr_scheduler #(.WIDTH(WIDTH), .CHANNEL(CHANNEL), .BURST(1)) u_b1 (
      .clk(clk), .rst(rst), .bus_io(if1), .locked_o(locked1)
   );
   chan_rr_scheduler #(.WIDTH(WIDTH), .CHANNEL(CHANNEL), .BURST(4)) u_b4 (
      .clk(clk), .rst(rst), .bus_io(if4), .locked_o(locked4)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_data(input bit sel4, input int base);
      for (int i = 0; i < CHANNEL; i++) begin
         if (sel4) if4.req_data[i*WIDTH +: WIDTH] = WIDTH'(base + i);
         else      if1.req_data[i*WIDTH +: WIDTH] = WIDTH'(base + i);
      end
   endtask

   task automatic push(input bit sel4, input int ch, input int base);
      logic [CHAN_W+WIDTH-1:0] e;
      e = {CHAN_W'(ch), WIDTH'(base + ch)};
      if (sel4) exp_q4.push_back(e);
      else      exp_q1.push_back(e);
   endtask

   task automatic chk_out(input bit sel4, input string tag);
      logic [CHAN_W+WIDTH-1:0] obs, e;
      logic v;
      int   sz;
      v   = sel4 ? if4.out_valid : if1.out_valid;
      obs = sel4 ? {if4.out_chan, if4.out_data} : {if1.out_chan, if1.out_data};
      sz  = sel4 ? exp_q4.size() : exp_q1.size();
      chk({tag, "_valid"}, 64'(v), 64'd1);
      if (sz == 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL %s_underflow observed=%0h expected=none", tag, obs);
      end else begin
         e = sel4 ? exp_q4.pop_front() : exp_q1.pop_front();
         chk(tag, 64'(obs), 64'(e));
      end
   endtask

   initial begin
      if1.req_valid = '0; if1.req_data = '0; if1.out_ready = 1'b0;
      if4.req_valid = '0; if4.req_data = '0; if4.out_ready = 1'b0;
      repeat (2) @(negedge clk);

      // reset state, with requests pending on the BURST=4 instance
      if4.req_valid = '1;
      #1;
      chk("rst_b1_valid", 64'(if1.out_valid), 64'd0);
      chk("rst_b1_ready", 64'(if1.req_ready), 64'd0);
      chk("rst_b4_valid", 64'(if4.out_valid), 64'd0);
      chk("rst_b4_chan",  64'(if4.out_chan),  64'd0);
      chk("rst_b4_data",  64'(if4.out_data),  64'd0);
      chk("rst_b4_lock",  64'(locked4),       64'd0);
      chk("rst_b4_ready", 64'(if4.req_ready), 64'd0);
      if4.req_valid = '0;

      // BURST=1 round robin over all five channels
      if1.req_valid = 5'h1F;
      set_data(0, 'hA0);
      if1.out_ready = 1'b1;
      if4.out_ready = 1'b1;
      for (int k = 0; k < 6; k++) push(0, k % 5, 'hA0);
      rst = 1'b0;
      #1;
      chk("rr_first_ready", 64'(if1.req_ready), 64'd1);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk_out(0, "rr_b1");
         chk("rr_b1_ready", 64'(if1.req_ready), 64'(1 << ((k + 1) % 5)));
      end
      if1.req_valid = '0;
      tick();
      chk("rr_drain_valid", 64'(if1.out_valid), 64'd0);
      chk("rr_hold_data",   64'(if1.out_data),  64'hA0);

      // BURST=4, channels 1 and 3 requesting continuously
      if4.req_valid = 5'b01010;
      set_data(1, 'hB0);
      for (int k = 0; k < 12; k++) push(1, ((k / 4) % 2 == 0) ? 1 : 3, 'hB0);
      for (int k = 0; k < 12; k++) begin
         tick();
         chk_out(1, "burst");
         chk("burst_locked", 64'(locked4), 64'((k % 4) != 3));
      end
      if4.req_valid = '0;
      tick();
      chk("burst_drain", 64'(if4.out_valid), 64'd0);

      // channel 2 drops after two beats; channel 4 takes over without a bubble
      if4.req_valid = 5'b10100;
      set_data(1, 'hC0);
      push(1, 2, 'hC0); push(1, 2, 'hC0);
      for (int k = 0; k < 2; k++) begin
         tick();
         chk_out(1, "drop_ch2");
         chk("drop_locked2", 64'(locked4), 64'd1);
      end
      if4.req_valid = 5'b10000;
      #1;
      chk("drop_ready", 64'(if4.req_ready), 64'b10000);
      for (int k = 0; k < 4; k++) push(1, 4, 'hC0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_out(1, "drop_ch4");
         chk("drop_locked4", 64'(locked4), 64'(k != 3));
      end
      if4.req_valid = '0;
      tick();

      // backpressure: stalled slot blocks all grants and holds its word
      if4.req_valid = 5'b00011;
      set_data(1, 'hD0);
      push(1, 0, 'hD0);
      tick();
      chk_out(1, "bp_first");
      if4.out_ready = 1'b0;
      if4.req_data[0 +: WIDTH] = 32'hD5;
      #1;
      chk("bp_ready", 64'(if4.req_ready), 64'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("bp_stall_ready", 64'(if4.req_ready), 64'd0);
         chk("bp_stall_valid", 64'(if4.out_valid), 64'd1);
         chk("bp_stall_data",  64'(if4.out_data),  64'hD0);
      end
      if4.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 64'(if4.req_ready), 64'd1);
      exp_q4.push_back({CHAN_W'(0), 32'hD5});
      tick();
      chk_out(1, "bp_next");
      if4.req_valid = '0;
      tick();
      chk("bp_drain",  64'(if4.out_valid), 64'd0);
      chk("bp_unlock", 64'(locked4),       64'd0);

      // reset mid-burst with a word in the output stage
      if4.req_valid = 5'h1F;
      set_data(1, 'hE0);
      push(1, 1, 'hE0); push(1, 1, 'hE0);
      tick();
      chk_out(1, "mid_a");
      tick();
      chk_out(1, "mid_b");
      chk("mid_locked", 64'(locked4), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(if4.out_valid), 64'd0);
      chk("mid_rst_chan",  64'(if4.out_chan),  64'd0);
      chk("mid_rst_data",  64'(if4.out_data),  64'd0);
      chk("mid_rst_lock",  64'(locked4),       64'd0);
      chk("mid_rst_ready", 64'(if4.req_ready), 64'd0);
      tick();
      chk("mid_rst_ready2", 64'(if4.req_ready), 64'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 64'(if4.req_ready), 64'd1);
      push(1, 0, 'hE0);
      tick();
      chk_out(1, "post_rst");
      if4.req_valid = '0;

      // BURST=1 modulo wrap between channels 4 and 0
      if1.req_valid = 5'b10001;
      set_data(0, 'hF0);
      push(0, 0, 'hF0); push(0, 4, 'hF0); push(0, 0, 'hF0); push(0, 4, 'hF0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_out(0, "wrap");
      end
      if1.req_valid = '0;
      tick();
      chk("queues_empty", 64'(exp_q1.size() + exp_q4.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/chan_rr_scheduler.md
# chan_rr_scheduler

Round-robin scheduler that shares one downstream processing slot among CHANNEL independent requesters. Each requester presents WIDTH-bit words with a valid/ready handshake. The block grants one channel per beat, with an optional burst lock, and registers the winning word together with its channel tag into a single-entry output stage. It sits in front of a shared datapath chain so that the per-channel lanes feeding the XOR-combined output can time-share one pipeline instead of instantiating one per channel.

## Interface
- WIDTH, 32, data word width.
- CHANNEL, 5, number of requesters (2..16).
- BURST, 4, maximum consecutive beats granted to one channel before forced rotation (1..255; 1 = pure per-beat round robin).
- CHAN_W (localparam), $clog2(CHANNEL), width of the channel tag.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset: asynchronous, active-high (clock clk).
- req_valid  in  CHANNEL  per-channel word valid.
- req_data  in  CHANNEL*WIDTH  channel i word at [i*WIDTH +: WIDTH].
- req_ready  out  CHANNEL  one-hot (or zero) grant; combinational.
- out_valid  out  1  output stage holds a word.
- out_data  out  WIDTH  granted word.
- out_chan  out  CHAN_W  source channel of out_data.
- out_ready  in  1  downstream accepts the output word.
- locked  out  1  scheduler is in the LOCK state.

## Operation
- slot_free = !out_valid || out_ready. No transfer is possible when slot_free is 0.
- State machine:
  - IDLE → LOCK on a transfer when BURST > 1.
  - LOCK → IDLE when beat_cnt reaches BURST, or when the lock channel drops req_valid while slot_free is 1.
- Registers:
  - ptr (CHAN_W): round-robin start point.
  - lock_ch (CHAN_W).
  - beat_cnt (8 bits).
- Selection in IDLE: the first i with req_valid[i] = 1, searching ptr, ptr+1, … modulo CHANNEL.
- Selection in LOCK:
  - If req_valid[lock_ch] = 1, lock_ch is selected.
  - Otherwise the lock releases combinationally that cycle and the IDLE search starts at lock_ch+1 (mod CHANNEL).
- req_ready[sel] = slot_free && any eligible request && !rst. All other bits are 0.
- req_ready never depends on the selected channel's own req_valid beyond selection. A requester may hold valid while waiting. A requester must not drop valid or change data before its handshake completes.
- On a transfer (req_valid[sel] && req_ready[sel]):
  - out_data ← word of sel, out_chan ← sel, out_valid ← 1.
  - ptr ← sel+1 (mod CHANNEL).
- Burst counting:
  - First beat of a burst: lock_ch ← sel, beat_cnt ← 1, state ← LOCK if BURST > 1.
  - Locked beat: beat_cnt ← beat_cnt+1.
  - When the incremented count equals BURST, state ← IDLE and beat_cnt ← 0.
- When out_ready = 1, out_valid = 1 and there is no transfer, out_valid ← 0. out_data and out_chan hold their last values.
- Simultaneous out_ready and a new transfer: the output stage is overwritten with the new word and out_valid stays 1. Zero bubbles.
- Modulo wrap: for non-power-of-2 CHANNEL, ptr and tag arithmetic wrap CHANNEL-1 → 0, never reaching an invalid index.
- Reset (any time, including mid-burst or with out_valid = 1):
  - out_valid = 0, out_data = 0, out_chan = 0, ptr = 0, lock_ch = 0, beat_cnt = 0, state IDLE, locked = 0.
  - req_ready = 0 while rst is high. An in-flight word is discarded.

## Timing
- Latency: 1 cycle from handshake edge to out_valid / out_data.
- Throughput: one word per cycle when out_ready is held 1.
- req_ready is a combinational function of req_valid, out_valid, out_ready and state. There are no combinational paths from req_data.
- First grant is possible on the first rising edge after rst deasserts.
- Fairness:
  - With all channels continuously requesting, each channel receives exactly BURST consecutive beats, in order 0, 1, …, CHANNEL-1, 0, …
  - Any requesting channel waits at most (CHANNEL-1)*BURST transfers.

## Test plan
- Reset: assert rst mid-burst with out_valid = 1 → next sample shows out_valid = 0, out_chan = 0, locked = 0, req_ready = 0; after release, channel 0 is granted first.
- BURST = 1, all five channels valid with data i = 32'hA0+i, out_ready = 1 → out_chan sequence 0,1,2,3,4,0; out_data 32'hA0..A4,A0; one word per cycle.
- BURST = 4, channels 1 and 3 valid continuously → out_chan 1,1,1,1,3,3,3,3,1…; locked = 1 during each burst.
- BURST = 4, channel 2 drops valid after 2 beats while channel 4 is valid → the next beat is channel 4 with no idle cycle; locked releases and re-locks onto 4.
- Backpressure: out_ready = 0 for 3 cycles with out_valid = 1 → req_ready all 0, out_data stable; out_ready = 1 → the word drains and the next grant occurs in the same cycle.
- CHANNEL = 5 wrap: only channel 4 then channel 0 requesting, BURST = 1 → alternating tags 4,0,4; ptr never reaches 5.
